// File: rtl/systolic_skew_feeder_pkg.sv
// Shared constants, lane derivation and FSM encoding for the systolic skew feeder.
package systolic_skew_feeder_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 256;
    localparam int unsigned DEFAULT_NUM_BITS   = 8;

    function automatic int unsigned lanes_of(input int unsigned data_width,
                                             input int unsigned num_bits);
        return data_width / num_bits;
    endfunction

    // The last row's top lane leaves the skew LANES-1 cycles after its lane 0.
    function automatic int unsigned drain_cycles_of(input int unsigned lanes);
        return lanes - 1;
    endfunction

    localparam int unsigned LANES        = lanes_of(DEFAULT_DATA_WIDTH, DEFAULT_NUM_BITS);
    localparam int unsigned DRAIN_CYCLES = drain_cycles_of(LANES);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StDrain  = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/systolic_skew_feeder_skew_delay_line.sv
// Fixed-depth shift register carrying {valid, data} for one systolic lane.
module systolic_skew_feeder_skew_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= {in_valid, in_data};
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign {out_valid, out_data} = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Splits fetched buffer words into lanes, skews lane k by k cycles and tracks tile
// boundaries, draining the skew after the last row and pulsing tile_done.
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 256,
    parameter int unsigned NUM_BITS      = 8,
    parameter int unsigned ROW_CNT_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_last,
    output logic                              in_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [DATA_WIDTH/NUM_BITS-1:0]    out_lane_valid,
    output logic                              tile_done,
    output logic [ROW_CNT_WIDTH-1:0]          row_count,
    output logic                              busy,
    output logic                              overflow_err
);

    localparam int unsigned NUM_LANES  = lanes_of(DATA_WIDTH, NUM_BITS);
    localparam int unsigned DRAIN_LEN  = drain_cycles_of(NUM_LANES);
    localparam int unsigned CNT_W      = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LEN - 1);

    feeder_state_t    state_q;
    logic [CNT_W-1:0] drain_cnt_q;
    logic             accept;

    assign in_ready = (state_q != StDrain);
    assign busy     = (state_q != StIdle);
    assign accept   = in_valid & in_ready;

    // Idle cycles inject zero bubbles so every row keeps its diagonal slot.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [NUM_BITS-1:0] lane_in;

        assign lane_in = accept ? in_data[k*NUM_BITS +: NUM_BITS] : '0;

        systolic_skew_feeder_skew_delay_line #(
            .DEPTH (k + 1),
            .WIDTH (NUM_BITS)
        ) u_skew_delay_line (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (accept),
            .in_data   (lane_in),
            .out_valid (out_lane_valid[k]),
            .out_data  (out_data[k*NUM_BITS +: NUM_BITS])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            drain_cnt_q  <= '0;
            row_count    <= '0;
            tile_done    <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            tile_done <= 1'b0;
            if (in_valid && !in_ready) begin
                overflow_err <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        row_count   <= ROW_CNT_WIDTH'(1);
                        drain_cnt_q <= '0;
                        state_q     <= in_last ? StDrain : StStream;
                    end
                end
                StStream: begin
                    if (accept) begin
                        if (row_count != '1) begin
                            row_count <= row_count + ROW_CNT_WIDTH'(1);
                        end
                        if (in_last) begin
                            drain_cnt_q <= '0;
                            state_q     <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    // Exit lines up with the final row reaching the top lane.
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_q   <= StIdle;
                        tile_done <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Table-driven bench for systolic_skew_feeder plus hand sequences for reset corners.
module tb_systolic_skew_feeder;

    localparam int DW = 256;
    localparam int NB = 8;
    localparam int LN = 32;
    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic [LN-1:0] out_lane_valid;
    logic          tile_done;
    logic [RW-1:0] row_count;
    logic          busy;
    logic          overflow_err;

    systolic_skew_feeder #(
        .DATA_WIDTH    (DW),
        .NUM_BITS      (NB),
        .ROW_CNT_WIDTH (RW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_lane_valid (out_lane_valid),
        .tile_done      (tile_done),
        .row_count      (row_count),
        .busy           (busy),
        .overflow_err   (overflow_err)
    );

    always #5 clk = ~clk;

    // Inputs applied before an edge, expected outputs seen just after it.
    typedef struct {
        logic          valid;
        logic          last;
        logic [DW-1:0] data;
        logic          exp_ready;
        logic          exp_done;
        logic          exp_busy;
        logic          exp_ovf;
        int unsigned   exp_rows;
    } vec_t;

    vec_t vecs[$];
    logic cur_ovf = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] fill_word(input logic [NB-1:0] b);
        logic [DW-1:0] w;
        for (int k = 0; k < LN; k++) w[k*NB +: NB] = b;
        return w;
    endfunction

    function automatic logic [DW-1:0] ramp_word(input logic [NB-1:0] base);
        logic [DW-1:0] w;
        for (int k = 0; k < LN; k++) w[k*NB +: NB] = base + NB'(k);
        return w;
    endfunction

    task automatic push(input logic v, input logic l, input logic [DW-1:0] d, input logic r,
                        input logic dn, input logic b, input int unsigned rows);
        vec_t e;
        e.valid     = v;
        e.last      = l;
        e.data      = d;
        e.exp_ready = r;
        e.exp_done  = dn;
        e.exp_busy  = b;
        e.exp_ovf   = cur_ovf;
        e.exp_rows  = rows;
        vecs.push_back(e);
    endtask

    // Entries for the 30 DRAIN cycles after the last-row edge, then the exit edge.
    task automatic push_drain(input int unsigned rows, input int ovf_idx,
                              input logic [DW-1:0] junk);
        for (int i = 1; i <= LN - 2; i++) begin
            if (i == ovf_idx) cur_ovf = 1'b1;
            push(i == ovf_idx, 1'b0, (i == ovf_idx) ? junk : '0, 1'b0, 1'b0, 1'b1, rows);
        end
        push(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, rows);
    endtask

    initial begin
        logic [DW-1:0] hist_d[$];
        logic          hist_v[$];
        logic          prev_ready;
        logic [DW-1:0] exp_d;
        logic [LN-1:0] exp_v;
        vec_t          e;

        // Single-row tile, lane k = k+1.
        push(1'b1, 1'b1, ramp_word(8'd1), 1'b0, 1'b0, 1'b1, 1);
        push_drain(1, -1, '0);
        // Four-row tile straight after the previous exit; every lane = 2i+2.
        for (int i = 0; i < 4; i++) begin
            push(1'b1, i == 3, fill_word(NB'(i * 2 + 2)), i != 3, 1'b0, 1'b1, i + 1);
        end
        push_drain(4, -1, '0);
        // Two rows separated by one bubble.
        push(1'b1, 1'b0, ramp_word(8'h10), 1'b1, 1'b0, 1'b1, 1);
        push(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1);
        push(1'b1, 1'b1, ramp_word(8'h40), 1'b0, 1'b0, 1'b1, 2);
        push_drain(2, -1, '0);
        // Single row, then a word pushed in the 3rd DRAIN cycle must be dropped.
        push(1'b1, 1'b1, fill_word(8'h77), 1'b0, 1'b0, 1'b1, 1);
        push_drain(1, 3, fill_word(8'hA5));
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1);

        // Reset held for three cycles.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("reset out_data", out_data, '0);
        check("reset out_lane_valid", DW'(out_lane_valid), '0);
        check("reset in_ready", DW'(in_ready), DW'(1));
        check("reset busy", DW'(busy), '0);
        check("reset tile_done", DW'(tile_done), '0);
        check("reset overflow_err", DW'(overflow_err), '0);
        check("reset row_count", DW'(row_count), '0);

        prev_ready = 1'b1;
        for (int n = 0; n < vecs.size(); n++) begin
            e        = vecs[n];
            in_valid = e.valid;
            in_last  = e.last;
            in_data  = e.data;
            hist_v.push_back(e.valid && prev_ready);
            hist_d.push_back((e.valid && prev_ready) ? e.data : '0);
            tick();
            exp_d = '0;
            exp_v = '0;
            for (int k = 0; k < LN; k++) begin
                int j;
                j = n - k;
                if (j >= 0 && hist_v[j]) begin
                    exp_v[k]          = 1'b1;
                    exp_d[k*NB +: NB] = hist_d[j][k*NB +: NB];
                end
            end
            check($sformatf("vec%0d out_data", n), out_data, exp_d);
            check($sformatf("vec%0d out_lane_valid", n), DW'(out_lane_valid), DW'(exp_v));
            check($sformatf("vec%0d in_ready", n), DW'(in_ready), DW'(e.exp_ready));
            check($sformatf("vec%0d tile_done", n), DW'(tile_done), DW'(e.exp_done));
            check($sformatf("vec%0d busy", n), DW'(busy), DW'(e.exp_busy));
            check($sformatf("vec%0d overflow_err", n), DW'(overflow_err), DW'(e.exp_ovf));
            check($sformatf("vec%0d row_count", n), DW'(row_count), DW'(e.exp_rows));
            prev_ready = e.exp_ready;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;

        // Reset asserted during DRAIN cycle 10.
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_data  = ramp_word(8'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        repeat (9) tick();
        check("middrain lane_valid", DW'(out_lane_valid), DW'(32'h0000_0200));
        check("middrain busy", DW'(busy), DW'(1));
        check("middrain in_ready", DW'(in_ready), '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst out_data", out_data, '0);
        check("midrst out_lane_valid", DW'(out_lane_valid), '0);
        check("midrst in_ready", DW'(in_ready), DW'(1));
        check("midrst busy", DW'(busy), '0);
        check("midrst tile_done", DW'(tile_done), '0);
        check("midrst overflow_err", DW'(overflow_err), '0);
        check("midrst row_count", DW'(row_count), '0);
        for (int i = 0; i < 40; i++) begin
            tick();
            check($sformatf("postrst%0d tile_done", i), DW'(tile_done), '0);
            check($sformatf("postrst%0d lane_valid", i), DW'(out_lane_valid), '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Downstream of the kT/Q/S/V/H BRAM fetch stage.
- Consumes the 256-bit words read from the intermediate buffer, one tile row per word, and splits each word into 8-bit lanes.
- Delays lane k by k cycles, producing the diagonal wavefront the systolic array's row inputs need.
- Tracks tile boundaries, drains the skew pipeline after the last row, and reports completion back to the arbiter.

Parameters:
- DATA_WIDTH, 256, width of one fetched buffer word.
- NUM_BITS, 8, width of one lane element (signed int8 activations).
- LANES, DATA_WIDTH/NUM_BITS = 32, number of systolic rows fed; derived, not overridden.
- ROW_CNT_WIDTH, 16, width of the per-tile row counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset: one clock; reset is synchronous and active-high.
- in_valid  in  1  in_data carries a fetched word (aligned with the fetch stage's doutb).
- in_data  in  DATA_WIDTH  fetched word; lane k = in_data[k*NUM_BITS +: NUM_BITS].
- in_last  in  1  qualifies the current word as the last row of the tile; ignored when in_valid=0.
- in_ready  out  1  block can accept a word this cycle.
- out_data  out  DATA_WIDTH  skewed lanes, same lane packing as in_data.
- out_lane_valid  out  LANES  per-lane valid for out_data.
- tile_done  out  1  one-cycle pulse when the last lane of the last row is presented.
- row_count  out  ROW_CNT_WIDTH  rows accepted in the current or most recent tile.
- busy  out  1  state != IDLE.
- overflow_err  out  1  sticky: a word arrived while in_ready=0.

Behaviour:
- Reset values: all outputs 0 except in_ready=1; state=IDLE. Reset is synchronous and takes priority over everything, including mid-DRAIN; the skew pipeline, counters and overflow_err all clear.
- Accept condition: accept = in_valid & in_ready.
- Skew: lane k is a register chain of depth k+1.
  - A word accepted at edge t presents lane k on out_data / out_lane_valid[k] in the cycle following edge t+k.
  - Lane 0 latency is 1 cycle; lane LANES-1 latency is LANES cycles.
- Bubbles: a cycle with no accept injects data 0 with valid 0 into every lane chain. Bubbles keep their diagonal position and are never compressed.
- FSM:
  - IDLE: on accept with in_last=0, go to STREAM, row_count=1. On accept with in_last=1, go to DRAIN, row_count=1.
  - STREAM: each accept increments row_count, saturating at all-ones. An accept with in_last=1 moves to DRAIN.
  - DRAIN: in_ready=0. Counts LANES-1 cycles, then returns to IDLE and pulses tile_done. The pulse coincides with out_lane_valid[LANES-1] for the final row.
- tile_done rules:
  - One cycle wide.
  - Not asserted during reset.
  - Never asserted without a preceding in_last accept.
- in_ready = (state != DRAIN).
- Overflow: in_valid=1 while in_ready=0:
  - The word is dropped and row_count is unchanged.
  - overflow_err sets and stays set until rst.
- row_count holds its value in IDLE and reloads to 1 on the first accept of the next tile.
- Simultaneous events:
  - The DRAIN-exit cycle has in_ready=0 (still DRAIN); a new tile may start on the following cycle.
  - Back-to-back tiles therefore incur LANES-1 idle input cycles. This is accepted.
- Data is passed unmodified; there is no arithmetic on lane values.

Decomposition:
- Shared package: LANES derivation, the state encoding (IDLE, STREAM, DRAIN), and the DRAIN_CYCLES = LANES-1 constant.
- One natural sub-module, skew_delay_line: parameterised DEPTH and WIDTH, a shift register carrying {valid, data}, synchronous clear.
- The top generate-instantiates LANES copies with DEPTH = k+1, plus the FSM and counters.

Test Plan:
- Reset check: hold rst 3 cycles, then check: out_data=0, out_lane_valid=0, in_ready=1, busy=0, tile_done=0, overflow_err=0.
- Single-row tile: accept one word with lane k = k+1 and in_last=1 at edge t.
  - Lane k shows k+1 with out_lane_valid = (1<<k) only, after edge t+k.
  - tile_done pulses after edge t+31.
  - row_count=1; in_ready=0 for cycles t+1..t+31.
- Four-row tile: words i=0..3 with every lane = i*2+2, contiguous, in_last on i=3.
  - Lane 31 emits 2,4,6,8 after edges t+31..t+34.
  - tile_done is coincident with the value 8; row_count=4.
- Bubble: rows 0 and 1 separated by one idle cycle.
  - Lane 0 valid pattern is 1,0,1; lane 5 shows the same pattern shifted by 5 cycles.
  - row_count=2.
- Overflow: drive in_valid=1 during the 3rd DRAIN cycle.
  - The word never appears on any lane.
  - overflow_err=1 and remains 1 after tile_done; row_count unchanged.
- Reset mid-DRAIN: assert rst at DRAIN cycle 10.
  - On the next cycle all outputs return to reset values and state is IDLE.
  - No tile_done pulse follows.
